// File: rtl/timer0_sfr.sv
// Timer/counter 0 with its TMOD/TCON/TL0/TH0 SFRs and the TF0 interrupt flag.
// Optional macro TIMER0_GATE_EN enables INT0 gating of the run condition via TMOD.GATE.
module timer0_sfr #(
  parameter int          PRESCALE  = 12,
  parameter logic [7:0]  TCON_ADDR = 8'h88,
  parameter logic [7:0]  TMOD_ADDR = 8'h89,
  parameter logic [7:0]  TL0_ADDR  = 8'h8A,
  parameter logic [7:0]  TH0_ADDR  = 8'h8C
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_t0,
  input  logic       i_int0,
  input  logic       i_tf0_ack,
  output logic [7:0] o_tmod,
  output logic [7:0] o_tcon,
  output logic [7:0] o_tl0,
  output logic [7:0] o_th0,
  output logic       o_tf0_irq
);
  localparam int PW = $clog2(PRESCALE);

  logic [7:0]    r_tmod, r_tcon, r_tl0, r_th0;
  logic [PW-1:0] r_pre;
  logic [2:0]    r_t0_s;      // [1:0] synchroniser, [2] previous synchronised value
  logic          w_run, w_t0_fall, w_pre_end, w_tick, w_ovf;
  logic          w_wr_tcon, w_wr_tmod, w_wl, w_wh;
  logic [7:0]    w_tl_n, w_th_n, w_tcon_n;

  assign w_wr_tcon = i_wr_en && (i_wr_addr == TCON_ADDR);
  assign w_wr_tmod = i_wr_en && (i_wr_addr == TMOD_ADDR);
  assign w_wl      = i_wr_en && (i_wr_addr == TL0_ADDR);
  assign w_wh      = i_wr_en && (i_wr_addr == TH0_ADDR);

`ifdef TIMER0_GATE_EN
  logic [1:0] r_int0_s;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_int0_s <= 2'b00;
    else          r_int0_s <= {r_int0_s[0], i_int0};
  assign w_run = r_tcon[4] & (~r_tmod[3] | r_int0_s[1]);
`else
  logic w_unused_int0;
  assign w_unused_int0 = i_int0;
  assign w_run = r_tcon[4];
`endif

  assign w_t0_fall = r_t0_s[2] & ~r_t0_s[1];
  assign w_pre_end = (r_pre == PW'(PRESCALE - 1));
  // A TCON write that stops the timer also swallows a tick landing on the same edge.
  assign w_tick = w_run & (r_tmod[2] ? w_t0_fall : w_pre_end)
                & ~(w_wr_tcon & ~i_wr_data[4]);

  // A written byte takes the write data and produces no carry or overflow of its own.
  always_comb begin
    w_tl_n = r_tl0;
    w_th_n = r_th0;
    w_ovf  = 1'b0;
    if (w_tick) begin
      case (r_tmod[1:0])
        2'd0: begin
          w_tl_n = {r_tl0[7:5], r_tl0[4:0] + 5'd1};
          if (r_tl0[4:0] == 5'h1f && !w_wl) begin
            w_th_n = r_th0 + 8'd1;
            w_ovf  = (r_th0 == 8'hff) && !w_wh;
          end
        end
        2'd2: begin
          if (r_tl0 == 8'hff) begin
            w_tl_n = r_th0;
            w_ovf  = !w_wl;
          end else begin
            w_tl_n = r_tl0 + 8'd1;
          end
        end
        default: begin
          w_tl_n = r_tl0 + 8'd1;
          if (r_tl0 == 8'hff && !w_wl) begin
            w_th_n = r_th0 + 8'd1;
            w_ovf  = (r_th0 == 8'hff) && !w_wh;
          end
        end
      endcase
    end
    if (w_wl) w_tl_n = i_wr_data;
    if (w_wh) w_th_n = i_wr_data;
  end

  // Hardware overflow beats any software clear of TF0.
  always_comb begin
    w_tcon_n = w_wr_tcon ? i_wr_data : r_tcon;
    if (i_tf0_ack) w_tcon_n[5] = 1'b0;
    if (w_ovf)     w_tcon_n[5] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmod <= 8'h00;
      r_tcon <= 8'h00;
      r_tl0  <= 8'h00;
      r_th0  <= 8'h00;
      r_pre  <= '0;
      r_t0_s <= 3'b000;
    end else begin
      r_t0_s <= {r_t0_s[1:0], i_t0};
      r_pre  <= (!w_run || w_pre_end) ? '0 : r_pre + PW'(1);
      if (w_wr_tmod) r_tmod <= i_wr_data;
      r_tcon <= w_tcon_n;
      r_tl0  <= w_tl_n;
      r_th0  <= w_th_n;
    end
  end

  assign o_tmod    = r_tmod;
  assign o_tcon    = r_tcon;
  assign o_tl0     = r_tl0;
  assign o_th0     = r_th0;
  assign o_tf0_irq = r_tcon[5];
endmodule

// File: tb/tb_timer0_sfr.sv
// Scoreboard bench for timer0_sfr: directed scenarios plus randomized traffic against a behavioural model.
module tb_timer0_sfr;
  localparam int P = 12;

  logic       i_clk, i_rst_n, i_wr_en, i_t0, i_int0, i_tf0_ack;
  logic [7:0] i_wr_addr, i_wr_data;
  logic [7:0] o_tmod, o_tcon, o_tl0, o_th0;
  logic       o_tf0_irq;

  timer0_sfr #(.PRESCALE(P)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_t0(i_t0), .i_int0(i_int0), .i_tf0_ack(i_tf0_ack),
    .o_tmod(o_tmod), .o_tcon(o_tcon), .o_tl0(o_tl0), .o_th0(o_th0), .o_tf0_irq(o_tf0_irq)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic [7:0] tmod, tcon, tl, th;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0, n_fail = 0;

  // Behavioural model: counter value as an integer, synchronisers as sample history.
  logic [7:0] m_tmod, m_tcon, m_tl, m_th;
  int         m_pre, m_v, m_ntl, m_nth;
  bit         m_t0h1, m_t0h2, m_t0h3, m_i0h1, m_i0h2;
  bit         m_run, m_tick, m_ovf, m_tf, m_wt, m_wm, m_wl, m_wh;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_tmod = 0; m_tcon = 0; m_tl = 0; m_th = 0; m_pre = 0;
      m_t0h1 = 0; m_t0h2 = 0; m_t0h3 = 0; m_i0h1 = 0; m_i0h2 = 0;
      q.delete();
    end else begin
      m_wt = i_wr_en && i_wr_addr == 8'h88;
      m_wm = i_wr_en && i_wr_addr == 8'h89;
      m_wl = i_wr_en && i_wr_addr == 8'h8A;
      m_wh = i_wr_en && i_wr_addr == 8'h8C;
`ifdef TIMER0_GATE_EN
      m_run = m_tcon[4] && (!m_tmod[3] || m_i0h2);
`else
      m_run = m_tcon[4];
`endif
      m_tick = m_run && (m_tmod[2] ? (m_t0h3 && !m_t0h2) : (m_pre == P - 1));
      if (m_wt && !i_wr_data[4]) m_tick = 0;
      m_pre = m_run ? (m_pre + 1) % P : 0;
      m_ntl = m_tl; m_nth = m_th; m_ovf = 0;
      if (m_tick) begin
        case (m_tmod[1:0])
          2'd0: begin
            m_v   = m_th * 32 + m_tl % 32 + 1;
            m_ovf = (m_v == 8192) && !m_wl && !m_wh;
            m_ntl = (m_tl / 32) * 32 + m_v % 32;
            m_nth = m_wl ? m_th : (m_v / 32) % 256;
          end
          2'd2: begin
            if (m_tl == 255) begin m_ntl = m_th; m_ovf = !m_wl; end
            else m_ntl = m_tl + 1;
          end
          default: begin
            m_v   = m_th * 256 + m_tl + 1;
            m_ovf = (m_v == 65536) && !m_wl && !m_wh;
            m_ntl = m_v % 256;
            m_nth = m_wl ? m_th : (m_v / 256) % 256;
          end
        endcase
      end
      if (m_wl) m_ntl = i_wr_data;
      if (m_wh) m_nth = i_wr_data;
      m_tf = m_ovf ? 1'b1 : i_tf0_ack ? 1'b0 : m_wt ? i_wr_data[5] : m_tcon[5];
      if (m_wt) m_tcon = i_wr_data;
      m_tcon[5] = m_tf;
      if (m_wm) m_tmod = i_wr_data;
      m_tl = 8'(m_ntl);
      m_th = 8'(m_nth);
      m_t0h3 = m_t0h2; m_t0h2 = m_t0h1; m_t0h1 = i_t0;
      m_i0h2 = m_i0h1; m_i0h1 = i_int0;
      q.push_back('{tmod: m_tmod, tcon: m_tcon, tl: m_tl, th: m_th});
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n && q.size() > 0) begin
      mon_e = q.pop_front();
      n_tests++;
      if ({o_tmod, o_tcon, o_tl0, o_th0, o_tf0_irq} !==
          {mon_e.tmod, mon_e.tcon, mon_e.tl, mon_e.th, mon_e.tcon[5]}) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got tmod=%h tcon=%h tl0=%h th0=%h irq=%b, expected tmod=%h tcon=%h tl0=%h th0=%h irq=%b",
                 $time, o_tmod, o_tcon, o_tl0, o_th0, o_tf0_irq,
                 mon_e.tmod, mon_e.tcon, mon_e.tl, mon_e.th, mon_e.tcon[5]);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    i_rst_n = 1'b0; i_wr_en = 1'b0; i_wr_addr = 8'h00; i_wr_data = 8'h00;
    i_t0 = 1'b1; i_int0 = 1'b0; i_tf0_ack = 1'b0;
    cyc(3);
    chk("reset_regs", {o_tmod, o_tcon}, 16'h0000);
    chk("reset_cnt", {o_th0, o_tl0}, 16'h0000);
    chk("reset_irq", {15'd0, o_tf0_irq}, 16'h0000);
    i_rst_n = 1'b1;
    cyc(2);

    // mode 1 rollover
    wr(8'h89, 8'h01); wr(8'h8A, 8'hFE); wr(8'h8C, 8'hFF); wr(8'h88, 8'h10);
    cyc(12);
    chk("m1_first_tick", {o_th0, o_tl0}, 16'hFFFF);
    cyc(12);
    chk("m1_wrap", {o_th0, o_tl0}, 16'h0000);
    chk("m1_tf0", {14'd0, o_tcon[5], o_tf0_irq}, 16'h0003);

    // mode 2 auto-reload then ack
    wr(8'h88, 8'h00); wr(8'h89, 8'h02); wr(8'h8C, 8'h9C); wr(8'h8A, 8'hFF); wr(8'h88, 8'h10);
    cyc(12);
    chk("m2_reload", {o_th0, o_tl0}, 16'h9C9C);
    chk("m2_tf0", {15'd0, o_tcon[5]}, 16'h0001);
    i_tf0_ack = 1'b1; cyc(1); i_tf0_ack = 1'b0;
    chk("m2_ack", {15'd0, o_tcon[5]}, 16'h0000);

    // mode 0 13-bit
    wr(8'h88, 8'h00); wr(8'h89, 8'h00); wr(8'h8C, 8'h00); wr(8'h8A, 8'hFF); wr(8'h88, 8'h10);
    cyc(12);
    chk("m0_carry", {o_th0, o_tl0}, 16'h01E0);
    wr(8'h88, 8'h00); wr(8'h8C, 8'hFF); wr(8'h8A, 8'hFF); wr(8'h88, 8'h10);
    cyc(12);
    chk("m0_wrap", {o_th0, o_tl0}, 16'h00E0);
    chk("m0_tf0", {15'd0, o_tcon[5]}, 16'h0001);

    // counter mode on T0 falling edges
    wr(8'h88, 8'h00); wr(8'h89, 8'h05); wr(8'h8A, 8'h00); wr(8'h8C, 8'h00); wr(8'h88, 8'h10);
    for (int k = 0; k < 5; k++) begin
      i_t0 = 1'b0; cyc(2); i_t0 = 1'b1; cyc(2);
    end
    chk("ct_count5", {o_th0, o_tl0}, 16'h0005);
    wr(8'h88, 8'h00);
    for (int k = 0; k < 4; k++) begin
      i_t0 = 1'b0; cyc(2); i_t0 = 1'b1; cyc(2);
    end
    chk("ct_stopped", {o_th0, o_tl0}, 16'h0005);

    // TL0 write landing on a tick
    wr(8'h89, 8'h01); wr(8'h8A, 8'h00); wr(8'h8C, 8'h00); wr(8'h88, 8'h10);
    cyc(11);
    wr(8'h8A, 8'h55);
    chk("wr_vs_tick", {o_th0, o_tl0}, 16'h0055);

    // overflow with simultaneous ack
    wr(8'h88, 8'h00); wr(8'h8A, 8'hFF); wr(8'h8C, 8'hFF); wr(8'h88, 8'h10);
    cyc(11);
    i_tf0_ack = 1'b1; cyc(1); i_tf0_ack = 1'b0;
    chk("ovf_vs_ack", {7'd0, o_tcon[5], o_tl0}, 16'h0100);

    // GATE behaviour
    wr(8'h88, 8'h00); wr(8'h89, 8'h09); wr(8'h8A, 8'h00); wr(8'h8C, 8'h00);
    i_int0 = 1'b0; cyc(3);
    wr(8'h88, 8'h10);
    cyc(30);
`ifdef TIMER0_GATE_EN
    chk("gate_frozen", {o_th0, o_tl0}, 16'h0000);
    i_int0 = 1'b1; cyc(40);
    chk("gate_resume", {15'd0, (o_tl0 != 8'h00)}, 16'h0001);
`else
    chk("gate_ignored", {o_th0, o_tl0}, 16'h0002);
`endif

    // reset in the middle of counting
    wr(8'h89, 8'h01); wr(8'h8A, 8'h40);
    cyc(5);
    @(posedge i_clk); #2 i_rst_n = 1'b0;
    #1 chk("rst_mid_regs", {o_tmod, o_tcon}, 16'h0000);
    chk("rst_mid_cnt", {o_th0, o_tl0}, 16'h0000);
    @(negedge i_clk); i_rst_n = 1'b1;
    cyc(30);
    chk("rst_after", {o_tcon, o_tl0}, 16'h0000);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      i_wr_en = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 5))
        0: i_wr_addr = 8'h88;
        1: i_wr_addr = 8'h89;
        2: i_wr_addr = 8'h8A;
        3: i_wr_addr = 8'h8C;
        4: i_wr_addr = 8'h88;
        default: i_wr_addr = 8'($urandom);
      endcase
      i_wr_data = 8'($urandom);
      if (i_wr_addr == 8'h88 && $urandom_range(0, 3) != 0) i_wr_data[4] = 1'b1;
      if (i_wr_addr == 8'h8A || i_wr_addr == 8'h8C)
        if ($urandom_range(0, 1) == 0) i_wr_data = 8'hF0 | 8'($urandom_range(0, 15));
      i_tf0_ack = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) i_t0 = ~i_t0;
      if ($urandom_range(0, 20) == 0) i_int0 = ~i_int0;
      @(negedge i_clk);
    end
    i_wr_en = 1'b0; i_tf0_ack = 1'b0;
    cyc(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
